coverfloat_vector_unpacker: RTL

- Reader side of the coverfloat coverage-vector stream. The harness writer emits each 804-bit cover vector as 26 words of 32 bits.
- This block reassembles the words, splits them into decoded fields and checks each field encoding against the coverfloat_pkg constants.
- It presents one record per vector to the coverage collector over a valid/ready handshake.
- It sits between the trace-stream source and the covergroup sampler.

---
 rtl/coverfloat_vector_unpacker_if.sv | 41 ++++
 rtl/coverfloat_vector_unpacker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/coverfloat_vector_unpacker_if.sv
// Stream/record bundle for coverfloat_vector_unpacker.
// master: trace source + coverage collector side; slave: the unpacker.
interface coverfloat_vector_unpacker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_op;
  logic [7:0]       out_rm;
  logic [127:0]     out_a;
  logic [127:0]     out_b;
  logic [127:0]     out_c;
  logic [7:0]       out_op_fmt;
  logic [127:0]     out_result;
  logic [7:0]       out_res_fmt;
  logic [7:0]       out_flags;
  logic             out_int_sign;
  logic [31:0]      out_int_exp;
  logic [191:0]     out_int_sig;
  logic [3:0]       out_err;
  logic [CNT_W-1:0] frame_err_cnt;
  logic [CNT_W-1:0] vec_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_op, out_rm, out_a, out_b, out_c,
           out_op_fmt, out_result, out_res_fmt, out_flags, out_int_sign,
           out_int_exp, out_int_sig, out_err, frame_err_cnt, vec_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_op, out_rm, out_a, out_b, out_c,
           out_op_fmt, out_result, out_res_fmt, out_flags, out_int_sign,
           out_int_exp, out_int_sig, out_err, frame_err_cnt, vec_cnt
  );
endinterface

// File: rtl/coverfloat_vector_unpacker.sv
// coverfloat_vector_unpacker: reassembles 26x32-bit words into one 804-bit
// cover vector, decodes it into fields and hands it to the collector over a
// valid/ready handshake. Framing errors are counted in frame_err_cnt.
// Optional macro COVERFLOAT_UNPACK_CHECK_EN enables the field encoding
// checks reported on out_err; without it out_err is constant zero.
module coverfloat_vector_unpacker #(
  parameter int CNT_W = 16
) (
  input logic                       clk,
  input logic                       reset,
  coverfloat_vector_unpacker_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} state_t;

  localparam logic [4:0] LAST_IDX = 5'd25;

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       top_q, top_d;
  logic [799:0]     asm_q, asm_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [803:0]     rec_q, rec_d;
  logic [3:0]       err_q, err_d;
  logic [CNT_W-1:0] ferr_q, ferr_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  logic         accept;
  logic         slot_free;
  logic         load;
  logic         frame_err;
  logic [803:0] vec_w;
  logic [3:0]   check_w;

  assign accept    = bus.in_valid && in_ready_q;
  assign slot_free = !out_valid_q || bus.out_ready;
  // Word 0 is shifted through the assembly register too; after 26 shifts only
  // words 1..25 remain, so the top nibble is captured separately at index 0.
  assign vec_w     = {top_q, asm_d};

  // Framing FSM: word collection, backpressure hold and error drain.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    top_d     = top_q;
    asm_d     = asm_q;
    frame_err = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          asm_d = {asm_q[767:0], bus.in_data};
          if (idx_q == '0) top_d = bus.in_data[3:0];
          if (idx_q != LAST_IDX) begin
            if (bus.in_last) begin
              frame_err = 1'b1;
              idx_d     = '0;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end else begin
            idx_d = '0;
            if (!bus.in_last) begin
              frame_err = 1'b1;
              state_d   = DRAIN;
            end else if (slot_free) begin
              load = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        if (accept && bus.in_last) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

`ifdef COVERFLOAT_UNPACK_CHECK_EN
  logic pad_q, pad_d;

  function automatic logic fmt_ok(input logic [7:0] f);
    logic ok;
    case (f)
      8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
      8'h81, 8'hC1, 8'h82, 8'hC2: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_ok(input logic [31:0] op);
    logic [27:0] major;
    logic [3:0]  max_minor;
    major = op[31:4];
    case (major)
      28'h5, 28'h8: max_minor = 4'd4;
      28'hB:        max_minor = 4'd1;
      28'hC:        max_minor = 4'd2;
      28'h10:       max_minor = 4'd3;
      default:      max_minor = 4'd0;
    endcase
    return (major >= 28'h1) && (major <= 28'h10) && (op[3:0] <= max_minor);
  endfunction

  // Word-0 pad flag, captured when the first word of a vector is accepted.
  always_comb begin
    pad_d = pad_q;
    if (state_q == COLLECT && accept && idx_q == '0) pad_d = |bus.in_data[31:4];
  end

  // Encoding checks on the vector being loaded.
  always_comb begin
    check_w    = '0;
    check_w[0] = !op_ok(vec_w[803:772]);
    check_w[1] = vec_w[771:764] > 8'd5;
    check_w[2] = !fmt_ok(vec_w[379:372]) || !fmt_ok(vec_w[243:236]);
    check_w[3] = pad_q || (|vec_w[2:0]);
  end

  // Pad flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pad_q <= 1'b0;
    else       pad_q <= pad_d;
  end
`else
  logic rsv_unused;
  assign check_w    = '0;
  assign rsv_unused = |rec_q[2:0];
`endif

  // Output record slot, handshake and saturating counters.
  always_comb begin
    rec_d       = rec_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    ferr_d      = ferr_q;
    vcnt_d      = vcnt_q;
    in_ready_d  = (state_d != HOLD);
    if (load) begin
      rec_d       = vec_w;
      err_d       = check_w;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (frame_err && ferr_q != '1) ferr_d = ferr_q + CNT_W'(1);
    if (out_valid_q && bus.out_ready && vcnt_q != '1) vcnt_d = vcnt_q + CNT_W'(1);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      top_q       <= '0;
      asm_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rec_q       <= '0;
      err_q       <= '0;
      ferr_q      <= '0;
      vcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      top_q       <= top_d;
      asm_q       <= asm_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      rec_q       <= rec_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      vcnt_q      <= vcnt_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_op        = rec_q[803:772];
  assign bus.out_rm        = rec_q[771:764];
  assign bus.out_a         = rec_q[763:636];
  assign bus.out_b         = rec_q[635:508];
  assign bus.out_c         = rec_q[507:380];
  assign bus.out_op_fmt    = rec_q[379:372];
  assign bus.out_result    = rec_q[371:244];
  assign bus.out_res_fmt   = rec_q[243:236];
  assign bus.out_flags     = rec_q[235:228];
  assign bus.out_int_sign  = rec_q[227];
  assign bus.out_int_exp   = rec_q[226:195];
  assign bus.out_int_sig   = rec_q[194:3];
  assign bus.out_err       = err_q;
  assign bus.frame_err_cnt = ferr_q;
  assign bus.vec_cnt       = vcnt_q;

endmodule
